// File: rtl/note_player.sv
// ----------------------------------------------------------------------------
// note_player
//
// Purpose:
//   Consumer end of the debounced key strobe path in the music box. A one-cycle
//   start strobe carries a 4-bit note code. The block then plays a square wave
//   at that pitch on the speaker pin for NOTE_MS milliseconds, stays silent for
//   GAP_MS milliseconds, and raises done for one cycle when both are complete.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  synchronous active-high reset, overrides everything
//   start  in   1  one-cycle request strobe, only looked at while idle
//   note   in   4  note code, captured together with start
//   busy   out  1  high from the cycle after acceptance through the last gap cycle
//   done   out  1  one-cycle pulse in the first idle cycle after the gap
//   spk    out  1  square-wave speaker drive, 0 whenever silent
//
// Note codes:
//   1..7   C4 D4 E4 F4 G4 A4 B4
//   8..14  the same seven notes one octave up (half-period halved)
//   0, 15  rest: the play phase runs for its full length with spk held at 0
// ----------------------------------------------------------------------------
module note_player #(
   parameter int CLK_HZ  = 50000000,
   parameter int NOTE_MS = 250,
   parameter int GAP_MS  = 20,
   parameter int MS_DIV  = CLK_HZ / 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] note,
   output logic       busy,
   output logic       done,
   output logic       spk
);

   // The ms counter has to hold the larger of the two phase lengths.
   localparam int MS_MAX = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
   localparam int MS_W   = $clog2(MS_MAX + 1);
   localparam int PRE_W  = $clog2(MS_DIV + 1);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(MS_DIV - 1);
   localparam logic [MS_W-1:0]  NOTE_LAST = MS_W'(NOTE_MS - 1);
   localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(GAP_MS - 1);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } stateT;

   stateT             state;
   stateT             nextState;

   logic [PRE_W-1:0]  prescale;
   logic [MS_W-1:0]   msCount;
   logic [16:0]       toneCount;
   logic [16:0]       halfReg;
   logic              spkReg;
   logic              doneReg;

   logic              prescaleLast;
   logic              playLast;
   logic              gapLast;

   // Half-period lookup, worked out at elaboration from the clock frequency.
   // Octave-up codes reuse the base entry shifted right by one. Rest codes
   // return zero, and a zero half-period keeps the tone generator silent.
   function automatic logic [16:0] halfOf(input logic [3:0] code);
      logic [16:0] h;
      case (code)
         4'd1, 4'd8:  h = 17'(CLK_HZ / (2 * 262));
         4'd2, 4'd9:  h = 17'(CLK_HZ / (2 * 294));
         4'd3, 4'd10: h = 17'(CLK_HZ / (2 * 330));
         4'd4, 4'd11: h = 17'(CLK_HZ / (2 * 349));
         4'd5, 4'd12: h = 17'(CLK_HZ / (2 * 392));
         4'd6, 4'd13: h = 17'(CLK_HZ / (2 * 440));
         4'd7, 4'd14: h = 17'(CLK_HZ / (2 * 494));
         default:     h = 17'd0;
      endcase
      if ((code >= 4'd8) && (code <= 4'd14)) begin
         h = h >> 1;
      end
      return h;
   endfunction

   // Phase-end detection. A phase ends on the cycle where the ms counter sits
   // on its last millisecond and the prescaler is about to wrap, so PLAY lasts
   // exactly NOTE_MS*MS_DIV cycles and GAP exactly GAP_MS*MS_DIV cycles.
   always_comb begin
      prescaleLast = (prescale == PRE_LAST);
      playLast     = (state == PLAY) && prescaleLast && (msCount == NOTE_LAST);
      gapLast      = (state == GAP)  && prescaleLast && (msCount == GAP_LAST);
   end

   // State register. Reset always returns to IDLE, even mid-note.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A start outside IDLE is simply dropped; nothing is
   // queued, so the sequencer has to retry after done.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = PLAY;
            end
         end
         PLAY: begin
            if (playLast) begin
               nextState = GAP;
            end
         end
         GAP: begin
            if (gapLast) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Outputs. busy follows the state directly; spk and done come straight from
   // registers so the speaker pin and the done strobe are glitch-free.
   always_comb begin
      busy = (state != IDLE);
      done = doneReg;
      spk  = spkReg;
   end

   // Datapath: millisecond timebase, tone generator and done strobe.
   // On acceptance the half-period is looked up once and held, so later
   // changes on the note input cannot bend the pitch of a note in progress.
   // The tone counter toggles spk when it reaches HALF-1, which puts the first
   // rising edge HALF cycles after entering PLAY. The final PLAY cycle forces
   // spk low even if a toggle would have landed there, so the gap always
   // starts silent. done is raised on the last GAP cycle and therefore shows
   // up in the first IDLE cycle, where it is cleared again one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescale  <= '0;
         msCount   <= '0;
         toneCount <= '0;
         halfReg   <= '0;
         spkReg    <= 1'b0;
         doneReg   <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               spkReg <= 1'b0;
               if (start) begin
                  halfReg   <= halfOf(note);
                  prescale  <= '0;
                  msCount   <= '0;
                  toneCount <= '0;
               end
            end
            PLAY: begin
               if (playLast) begin
                  prescale  <= '0;
                  msCount   <= '0;
                  toneCount <= '0;
                  spkReg    <= 1'b0;
               end else begin
                  if (prescaleLast) begin
                     prescale <= '0;
                     msCount  <= msCount + 1'b1;
                  end else begin
                     prescale <= prescale + 1'b1;
                  end
                  if (halfReg == 17'd0) begin
                     toneCount <= '0;
                     spkReg    <= 1'b0;
                  end else if (toneCount == (halfReg - 17'd1)) begin
                     toneCount <= '0;
                     spkReg    <= ~spkReg;
                  end else begin
                     toneCount <= toneCount + 17'd1;
                  end
               end
            end
            GAP: begin
               spkReg    <= 1'b0;
               toneCount <= '0;
               if (gapLast) begin
                  prescale <= '0;
                  msCount  <= '0;
                  doneReg  <= 1'b1;
               end else if (prescaleLast) begin
                  prescale <= '0;
                  msCount  <= msCount + 1'b1;
               end else begin
                  prescale <= prescale + 1'b1;
               end
            end
            default: begin
               spkReg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_player.sv
// ----------------------------------------------------------------------------
// tb_note_player
//
// Self-checking bench for note_player. A scaled-down clock (100 kHz, so one
// millisecond is 100 cycles) keeps every note short. For each note the
// reference model accepts, the stimulus side pushes the full expected event
// list (every spk edge and the done pulse, each stamped with its cycle) into
// a queue. An independent monitor pops and compares whenever the DUT shows an
// spk edge or a done pulse, and checks busy whenever it changes.
// ----------------------------------------------------------------------------
module tb_note_player;

   localparam int CLK_HZ  = 100000;
   localparam int NOTE_MS = 4;
   localparam int GAP_MS  = 1;
   localparam int MS_DIV  = CLK_HZ / 1000;
   localparam int PLAY_CYC = NOTE_MS * MS_DIV;
   localparam int GAP_CYC  = GAP_MS * MS_DIV;
   localparam int FAR_PAST = -1000000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] note = 4'd0;
   logic       busy;
   logic       done;
   logic       spk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   typedef struct {
      int at;
      bit isDone;
      bit level;
   } evtT;

   evtT expQ[$];
   int  nextFree = 0;
   int  curEntry = FAR_PAST;

   bit prevSpk = 1'b0;
   bit prevBusy = 1'b0;
   bit prevExpBusy = 1'b0;

   note_player #(
      .CLK_HZ (CLK_HZ),
      .NOTE_MS(NOTE_MS),
      .GAP_MS (GAP_MS)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .note (note),
      .busy (busy),
      .done (done),
      .spk  (spk)
   );

   // Free-running clock and a cycle counter that counts rising edges.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Pitch from the note rules: base frequencies, octave-up halves the
   // half-period, 0 and 15 are rests.
   function automatic int halfFor(input int code);
      int freqs[7];
      freqs = '{262, 294, 330, 349, 392, 440, 494};
      if (code == 0 || code == 15) begin
         return 0;
      end
      if (code <= 7) begin
         return CLK_HZ / (2 * freqs[code - 1]);
      end
      return (CLK_HZ / (2 * freqs[code - 8])) / 2;
   endfunction

   // Reference model for one accepted note entering PLAY at cycle k. The
   // waveform is a square wave starting low with an edge every HALF cycles
   // while still inside the play window, forced low at the window end, and
   // done appears once play plus gap have elapsed.
   function automatic void modelAccept(input int k, input int code);
      int  h;
      bit  level;
      evtT e;
      h = halfFor(code);
      level = 1'b0;
      if (h > 0) begin
         for (int j = 1; j * h < PLAY_CYC; j++) begin
            level = ~level;
            e.at = k + j * h;
            e.isDone = 1'b0;
            e.level = level;
            expQ.push_back(e);
         end
      end
      if (level) begin
         e.at = k + PLAY_CYC;
         e.isDone = 1'b0;
         e.level = 1'b0;
         expQ.push_back(e);
      end
      e.at = k + PLAY_CYC + GAP_CYC;
      e.isDone = 1'b1;
      e.level = 1'b1;
      expQ.push_back(e);
      curEntry = k;
      nextFree = k + PLAY_CYC + GAP_CYC + 1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Drive one cycle of inputs, starting at a falling edge. The model decides
   // whether the upcoming rising edge accepts the strobe: only once the
   // previous note has fully finished.
   task automatic applyStimulus(input bit s, input logic [3:0] n);
      start = s;
      note = n;
      if (s && (cyc + 1 >= nextFree)) begin
         modelAccept(cyc + 1, int'(n));
      end
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 4'($urandom_range(0, 15)));
      end
   endtask

   // Monitor: compares every spk edge and done pulse against the head of the
   // expected queue, flags events that never arrived, and checks busy each
   // time either the DUT or the model changes it.
   always @(negedge clk) begin
      bit  expBusy;
      evtT e;
      if (rst) begin
         prevSpk = spk;
         prevBusy = busy;
         prevExpBusy = 1'b0;
      end else begin
         expBusy = (cyc >= curEntry) && (cyc < curEntry + PLAY_CYC + GAP_CYC);
         while (expQ.size() > 0 && expQ[0].at < cyc) begin
            e = expQ.pop_front();
            checkOutput(e.isDone ? "missingDoneAtCycle" : "missingSpkEdgeAtCycle", cyc, e.at);
         end
         if (spk !== prevSpk) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedSpkEdgeCycle", cyc, -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("spkEdgeCycle", cyc, e.at);
               checkOutput("spkEdgeIsNotDone", 0, int'(e.isDone));
               checkOutput("spkLevel", int'(spk), int'(e.level));
            end
         end
         if (done === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedDoneCycle", cyc, -1);
            end else begin
               e = expQ.pop_front();
               checkOutput("doneCycle", cyc, e.at);
               checkOutput("doneIsDoneEvent", 1, int'(e.isDone));
            end
         end
         if ((busy !== prevBusy) || (expBusy != prevExpBusy)) begin
            checkOutput("busy", int'(busy), int'(expBusy));
         end
         prevSpk = spk;
         prevBusy = busy;
         prevExpBusy = expBusy;
      end
   end

   // Main stimulus sequence: reset, directed cases, then randomized traffic.
   initial begin
      int drain;
      $display("[TB] note_player bench, %0d play + %0d gap cycles per note", PLAY_CYC, GAP_CYC);

      repeat (3) @(negedge clk);
      checkOutput("resetSpk", int'(spk), 0);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetDone", int'(done), 0);
      rst = 1'b0;

      // A4 tone followed by the full gap.
      applyStimulus(1'b1, 4'd6);
      idleCycles(PLAY_CYC + GAP_CYC + 5);

      // Reset in the middle of a note: clean idle, no done afterwards.
      applyStimulus(1'b1, 4'd6);
      idleCycles(250);
      rst = 1'b1;
      @(posedge clk);
      #1;
      expQ.delete();
      nextFree = 0;
      curEntry = FAR_PAST;
      @(negedge clk);
      checkOutput("midResetSpk", int'(spk), 0);
      checkOutput("midResetBusy", int'(busy), 0);
      checkOutput("midResetDone", int'(done), 0);
      rst = 1'b0;
      idleCycles(PLAY_CYC + GAP_CYC + 20);

      // Octave-up and rest codes.
      applyStimulus(1'b1, 4'd13);
      idleCycles(PLAY_CYC + GAP_CYC + 3);
      applyStimulus(1'b1, 4'd0);
      idleCycles(PLAY_CYC + GAP_CYC + 3);
      applyStimulus(1'b1, 4'd15);
      idleCycles(PLAY_CYC + GAP_CYC + 3);

      // Lockout: starts during PLAY and during GAP are ignored.
      applyStimulus(1'b1, 4'd1);
      idleCycles(150);
      applyStimulus(1'b1, 4'd5);
      idleCycles(300);
      applyStimulus(1'b1, 4'd3);
      idleCycles(60);

      // Back-to-back: a start in the done cycle is accepted.
      applyStimulus(1'b1, 4'd4);
      idleCycles(PLAY_CYC + GAP_CYC);
      checkOutput("b2bDoneInDoneCycle", int'(done), 1);
      checkOutput("b2bBusyLowInDoneCycle", int'(busy), 0);
      applyStimulus(1'b1, 4'd2);
      idleCycles(PLAY_CYC + GAP_CYC + 3);

      // Start held high: one note per play+gap+1 cycles.
      for (int i = 0; i < 3 * (PLAY_CYC + GAP_CYC + 1) + 2; i++) begin
         applyStimulus(1'b1, 4'd7);
      end
      idleCycles(PLAY_CYC + GAP_CYC + 3);

      // Randomized traffic with stray starts and note changes while busy.
      for (int n = 0; n < 25; n++) begin
         int len;
         applyStimulus(1'b1, 4'($urandom_range(0, 15)));
         len = $urandom_range(0, PLAY_CYC + GAP_CYC + 30);
         for (int i = 0; i < len; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
         end
      end

      // Let every outstanding expected event come due, with a bounded wait.
      drain = 0;
      while (expQ.size() > 0 && drain < PLAY_CYC + GAP_CYC + 10) begin
         applyStimulus(1'b0, 4'd0);
         drain++;
      end
      idleCycles(2);
      checkOutput("expectedQueueDrained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
